// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: ALU function codes, sequencer state encoding, widths.
package ex_pkg;

  localparam int DATA_W    = 32;
  localparam int MUL_ITERS = 32;

  localparam logic [4:0] FS_PASS = 5'b00000;
  localparam logic [4:0] FS_ADD  = 5'b00010;
  localparam logic [4:0] FS_SUB  = 5'b00100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

  function automatic logic [2*DATA_W-1:0] neg2x(input logic [2*DATA_W-1:0] v);
    return ~v + {{(2*DATA_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/ex_alu_mux.sv
// Ownership mux in front of EX: pipeline controls pass through unless the
// multiply sequencer owns the ALU; memory write can be suppressed independently.
module ex_alu_mux
  import ex_pkg::*;
(
  input  logic              sel_seq,
  input  logic              mw_kill,
  input  logic [4:0]        pl_fs,
  input  logic [4:0]        pl_sh,
  input  logic [DATA_W-1:0] pl_a,
  input  logic [DATA_W-1:0] pl_b,
  input  logic              pl_mw,
  input  logic [4:0]        seq_fs,
  input  logic [4:0]        seq_sh,
  input  logic [DATA_W-1:0] seq_a,
  input  logic [DATA_W-1:0] seq_b,
  output logic [4:0]        alu_fs,
  output logic [4:0]        alu_sh,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_mw
);

  always_comb begin
    alu_fs = pl_fs;
    alu_sh = pl_sh;
    alu_a  = pl_a;
    alu_b  = pl_b;
    alu_mw = pl_mw & ~mw_kill;
    if (sel_seq) begin
      alu_fs = seq_fs;
      alu_sh = seq_sh;
      alu_a  = seq_a;
      alu_b  = seq_b;
      alu_mw = 1'b0;
    end
  end

endmodule

// File: rtl/ex_mul_seq.sv
// Shift-and-add 32x32 multiply sequencer that borrows the EX ALU and stalls the pipeline.
// Optional signed support is enabled by defining EX_MUL_SEQ_SIGNED_EN.
module ex_mul_seq
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] mul_a,
  input  logic [31:0] mul_b,
  input  logic [4:0]  pl_fs,
  input  logic [4:0]  pl_sh,
  input  logic [31:0] pl_a,
  input  logic [31:0] pl_b,
  input  logic        pl_mw,
  input  logic [31:0] alu_f,
  input  logic        alu_c,
  output logic [4:0]  alu_fs,
  output logic [4:0]  alu_sh,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_mw,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] prod_hi,
  output logic [31:0] prod_lo
);

  mul_state_e        state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mq_q, mq_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] prod_hi_q, prod_hi_d;
  logic [DATA_W-1:0] prod_lo_q, prod_lo_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              neg_pend_q, neg_pend_d;

  logic [DATA_W-1:0] a_mag, b_mag;
  logic              neg_req;
  logic              sel_seq, mw_kill;
  logic [DATA_W-1:0] seq_b;

`ifdef EX_MUL_SEQ_SIGNED_EN
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
    return (v < 0) ? DATA_W'(-v) : DATA_W'(v);
  endfunction

  // The most negative operand's magnitude 0x80000000 is correct when read unsigned.
  always_comb begin
    a_mag   = sgn ? mag(mul_a) : mul_a;
    b_mag   = sgn ? mag(mul_b) : mul_b;
    neg_req = sgn & (mul_a[31] ^ mul_b[31]);
  end
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign a_mag      = mul_a;
  assign b_mag      = mul_b;
  assign neg_req    = 1'b0;
`endif

  assign seq_b = mq_q[0] ? mcand_q : '0;

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mq_d       = mq_q;
    acc_hi_d   = acc_hi_q;
    cnt_d      = cnt_q;
    neg_pend_d = neg_pend_q;
    prod_hi_d  = prod_hi_q;
    prod_lo_d  = prod_lo_q;
    sel_seq    = 1'b0;
    mw_kill    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d    = a_mag;
          mq_d       = b_mag;
          acc_hi_d   = '0;
          cnt_d      = '0;
          neg_pend_d = neg_req;
          state_d    = RUN;
        end
      end
      RUN: begin
        sel_seq = 1'b1;
        busy    = 1'b1;
        // The ALU carry becomes the new top bit as the 64-bit pair shifts right.
        {acc_hi_d, mq_d} = {alu_c, alu_f, mq_q[DATA_W-1:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(MUL_ITERS - 1)) state_d = neg_pend_q ? NEG : DONE;
      end
      NEG: begin
        busy             = 1'b1;
        mw_kill          = 1'b1;
        {acc_hi_d, mq_d} = neg2x({acc_hi_q, mq_q});
        state_d          = DONE;
      end
      DONE: begin
        done      = 1'b1;
        prod_hi_d = acc_hi_q;
        prod_lo_d = mq_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mq_q       <= '0;
      acc_hi_q   <= '0;
      cnt_q      <= '0;
      neg_pend_q <= 1'b0;
      prod_hi_q  <= '0;
      prod_lo_q  <= '0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mq_q       <= mq_d;
      acc_hi_q   <= acc_hi_d;
      cnt_q      <= cnt_d;
      neg_pend_q <= neg_pend_d;
      prod_hi_q  <= prod_hi_d;
      prod_lo_q  <= prod_lo_d;
    end
  end

  assign stall   = busy;
  assign prod_hi = prod_hi_q;
  assign prod_lo = prod_lo_q;

  ex_alu_mux u_alu_mux (
    .sel_seq (sel_seq),
    .mw_kill (mw_kill),
    .pl_fs   (pl_fs),
    .pl_sh   (pl_sh),
    .pl_a    (pl_a),
    .pl_b    (pl_b),
    .pl_mw   (pl_mw),
    .seq_fs  (FS_ADD),
    .seq_sh  (5'd0),
    .seq_a   (acc_hi_q),
    .seq_b   (seq_b),
    .alu_fs  (alu_fs),
    .alu_sh  (alu_sh),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_mw  (alu_mw)
  );

endmodule

// File: doc/ex_mul_seq.md
# ex_mul_seq

Multi-cycle shift-and-add multiply sequencer that borrows the EX-stage ALU. When idle it forwards the pipeline's function select, operands, shift and memory-write controls to EX unchanged. On `start` it takes ownership of the ALU for 32 iterations, issuing ADD operations and accumulating a 64-bit product, while it stalls the pipeline. It sits between the ID/EX pipeline register and the EX datapath.

## Interface
- Parameters: none. Width is fixed at 32 bits and iteration count at 32.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: multiply request. It is sampled only in IDLE.
- `sgn` in 1: signed request. It is used only with `EX_MUL_SEQ_SIGNED_EN`.
- `mul_a`, `mul_b` in 32: multiplicand and multiplier, latched on accept.
- `pl_fs` in 5, `pl_sh` in 5, `pl_a` in 32, `pl_b` in 32, `pl_mw` in 1: the pipeline's requested EX controls.
- `alu_f` in 32, `alu_c` in 1: EX result F and carry C, combinational in the same cycle.
- `alu_fs` out 5, `alu_sh` out 5, `alu_a` out 32, `alu_b` out 32, `alu_mw` out 1: controls driven to EX.
- `busy` out 1: high in RUN or NEG.
- `stall` out 1: equal to `busy`. It holds IF/ID/EX registers.
- `done` out 1: one-cycle pulse when the product is valid.
- `prod_hi`, `prod_lo` out 32: product. It holds until the next accept.

## Operation
- States are IDLE, RUN, NEG and DONE. Encoding lives in the package.
- **IDLE**
  - `alu_*` equal `pl_*`, a pure combinational passthrough.
  - If `start`=1, latch `mcand`=`mul_a` and `mq`=`mul_b`, clear `acc_hi`, set `cnt`=0, and go to RUN.
- **RUN**
  - Outputs driven to EX:
    - `alu_fs`=FS_ADD
    - `alu_a`=`acc_hi`
    - `alu_b`=`mq[0]` ? `mcand` : 0
    - `alu_sh`=0
    - `alu_mw`=0 (forced, so the sequencer never writes memory)
  - Register update: {`acc_hi`,`mq`} <= {`alu_c`,`alu_f`,`mq[31:1]`}, and `cnt` <= `cnt`+1.
  - When `cnt`==31, go to DONE, or to NEG if negation is pending.
- **NEG**: internal 64-bit two's-complement negate of {`acc_hi`,`mq`} in one cycle, then go to DONE. The ALU is driven as in IDLE with `alu_mw`=0.
- **DONE**
  - `done`=1 and `busy`=0.
  - Copy {`acc_hi`,`mq`} to `prod_hi`/`prod_lo`.
  - ALU passthrough resumes and the state returns to IDLE.
  - `start` is not accepted in DONE.
- Boundary conditions:
  - `start` while busy or in DONE is ignored and not queued.
  - `cnt` is 5 bits and wraps 31 to 0 only on exit.
  - An operand of 0 still takes the full 32 iterations.
  - `reset` overrides everything, including mid-RUN. The next state is IDLE and the partial product is discarded.
- Reset values:
  - State is IDLE, and `busy`=`stall`=`done`=0.
  - `prod_hi`=`prod_lo`=0, `cnt`=0, `acc_hi`=`mq`=`mcand`=0.
  - `alu_*` are passthrough, since they are combinational from `pl_*`.

## Timing
- Accept at edge 0. RUN occupies cycles 1–32. `done` is high in cycle 33, with the product registered at the end of cycle 33.
  - Unsigned latency is 33 cycles from accept to the `done` cycle.
  - Signed with a negative result is 34.
- `stall` rises the cycle after accept and falls in the DONE cycle.
- The earliest back-to-back `start` is accepted the cycle after DONE.
- EX is combinational from `alu_*` to `alu_f`/`alu_c` within one cycle. There is no registered ALU path.

## Configuration
- `EX_MUL_SEQ_SIGNED_EN` defined:
  - On accept with `sgn`=1, latch |`mul_a`| and |`mul_b`|, and set `neg_pend` = `mul_a[31]` XOR `mul_b[31]`.
  - RUN exits to NEG when `neg_pend`=1.
  - −2^31 magnitude is handled as unsigned 0x80000000.
- Not defined: `sgn` is ignored, there is no NEG state, and all operands are unsigned.

## Structure
- Shared package `ex_pkg`:
  - FS codes: FS_ADD=5'b00010, FS_SUB=5'b00100, FS_PASS=5'b00000.
  - State typedef: IDLE=2'd0, RUN=2'd1, NEG=2'd2, DONE=2'd3.
  - Constants: MUL_ITERS=32, DATA_W=32.
- One sub-module is natural: `ex_alu_mux`, the ownership mux selecting pipeline or sequencer controls to EX. Everything else is flat.

## Test plan
- Idle passthrough: `pl_fs`=00100, `pl_a`=7FF00FFF, `pl_b`=7FFFFFFF, `pl_mw`=1.
  - Expect the `alu_*` mirror in the same cycle and `stall`=0.
- 3×5: `start` with `mul_a`=3, `mul_b`=5.
  - Expect `stall` high for 32 cycles and `alu_mw`=0 throughout.
  - Expect `done` at accept+33 with `prod_hi`=0 and `prod_lo`=0000000F.
- FFFFFFFF×FFFFFFFF: expect `prod_hi`=FFFFFFFE and `prod_lo`=00000001, proving carry propagation through `alu_c`.
- `start` pulsed at accept+10 with different operands:
  - Expect it ignored, and the original product and `done` timing unchanged.
- `reset` asserted at accept+12 for one cycle:
  - Expect IDLE next cycle, `busy`=`stall`=0, `prod`=0, no `done`, and passthrough restored.
- With `EX_MUL_SEQ_SIGNED_EN`, `sgn`=1, −3×5:
  - Expect `done` at accept+34 with `prod_hi`=FFFFFFFF and `prod_lo`=FFFFFFF1.
